// File: rtl/gf_pkg.sv
// Shared types and helpers for the iterative GF(2^WIDTH) multiplier.
// Constant field polynomial, FSM state type, xtime and lane slicing helpers.
package gf_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_LANES = 4;
    localparam logic [8:0] GF_POLY_AES = 9'h11B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } gf_state_t;

    // Multiply by x modulo poly; only the low 'width' bits are meaningful.
    function automatic logic [MAX_WIDTH-1:0] xtime(input logic [MAX_WIDTH-1:0] a,
                                                   input logic [MAX_WIDTH:0]   poly,
                                                   input int                   width);
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] r;
        logic                 msb;
        mask = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            mask[i] = (i < width);
        end
        msb = |(a & (MAX_WIDTH'(1) << (width - 1)));
        r   = (a << 1) & mask;
        if (msb) begin
            r = r ^ (poly[MAX_WIDTH-1:0] & mask);
        end
        return r;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/gf_mult_iter_if.sv
// Operand/product handshake bundle for gf_mult_iter.
// master = producer/consumer side, slave = the multiplier.
interface gf_mult_iter_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] multiplicand;
    logic [LANES*WIDTH-1:0] multiplier;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] product;
    logic                   busy;

    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/gf_lane_step.sv
// One lane of shift-and-add GF multiplication, BITS_PER_CYCLE LSB-first steps
// unrolled combinationally.
module gf_lane_step
    import gf_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH:0]   POLY           = (WIDTH+1)'(GF_POLY_AES),
    parameter int               BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] a_v;
    logic [WIDTH-1:0] b_v;
    logic [WIDTH-1:0] acc_v;

    always_comb begin
        a_v   = a;
        b_v   = b;
        acc_v = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (b_v[0]) begin
                acc_v = acc_v ^ a_v;
            end
            a_v = WIDTH'(xtime(MAX_WIDTH'(a_v), (MAX_WIDTH+1)'(POLY), WIDTH));
            b_v = b_v >> 1;
        end
        a_next   = a_v;
        b_next   = b_v;
        acc_next = acc_v;
    end

endmodule

// File: rtl/gf_mult_iter.sv
// Multi-lane iterative GF(2^WIDTH) multiplier with valid/ready handshake.
// Optional GF_EARLY_EXIT_EN: finish as soon as every lane's remaining multiplier is zero.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | stepping all lanes, BITS_PER_CYCLE multiplier bits per cycle
// DONE  | product held with out_valid until out_ready
module gf_mult_iter
    import gf_pkg::*;
#(
    parameter int             WIDTH          = 8,
    parameter logic [WIDTH:0] POLY           = (WIDTH+1)'(GF_POLY_AES),
    parameter int             LANES          = 4,
    parameter int             BITS_PER_CYCLE = 1
) (
    input logic           clock,
    input logic           reset_n,
    gf_mult_iter_if.slave bus
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    gf_state_t              state;
    logic [LANES*WIDTH-1:0] a_q;
    logic [LANES*WIDTH-1:0] b_q;
    logic [LANES*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]       cnt;
    logic [LANES*WIDTH-1:0] product_q;
    logic                   out_valid_q;
    logic                   busy_q;

    logic [LANES*WIDTH-1:0] a_nx;
    logic [LANES*WIDTH-1:0] b_nx;
    logic [LANES*WIDTH-1:0] acc_nx;
    logic                   in_ready_c;
    logic                   accept;
    logic                   finish;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        gf_lane_step #(
            .WIDTH          (WIDTH),
            .POLY           (POLY),
            .BITS_PER_CYCLE (BITS_PER_CYCLE)
        ) u_step (
            .a        (a_q   [lane_lo(g, WIDTH) +: WIDTH]),
            .b        (b_q   [lane_lo(g, WIDTH) +: WIDTH]),
            .acc      (acc_q [lane_lo(g, WIDTH) +: WIDTH]),
            .a_next   (a_nx  [lane_lo(g, WIDTH) +: WIDTH]),
            .b_next   (b_nx  [lane_lo(g, WIDTH) +: WIDTH]),
            .acc_next (acc_nx[lane_lo(g, WIDTH) +: WIDTH])
        );
    end

    // DONE with out_ready also accepts, giving back-to-back transactions.
    assign in_ready_c = reset_n & ((state == IDLE) | ((state == DONE) & bus.out_ready));
    assign accept     = bus.in_valid & in_ready_c;

`ifdef GF_EARLY_EXIT_EN
    assign finish = (cnt == CNT_LAST) | (b_nx == '0);
`else
    assign finish = (cnt == CNT_LAST);
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt         <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q    <= bus.multiplicand;
                        b_q    <= bus.multiplier;
                        acc_q  <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    a_q   <= a_nx;
                    b_q   <= b_nx;
                    acc_q <= acc_nx;
                    cnt   <= cnt + CNT_W'(1);
                    if (finish) begin
                        product_q   <= acc_nx;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            a_q    <= bus.multiplicand;
                            b_q    <= bus.multiplier;
                            acc_q  <= '0;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.busy      = busy_q;

endmodule
